// File: rtl/mha_pkg.sv
// Shared Q2.13 constants, dot-product sizing and the dot-product FSM state type.
package mha_pkg;
  localparam logic signed [15:0] Q213_ONE = 16'sh2000;
  localparam logic signed [15:0] Q213_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q213_MIN = 16'sh8000;

  localparam int MAX_LEN = 16;
  localparam int ACC_W   = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/sat_q213.sv
// Clips a signed W-bit accumulator into the Q2.13 range; combinational, no backpressure.
module sat_q213
  import mha_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic signed [W-1:0] acc_i,
  output logic        [15:0]  sum_o,
  output logic                clip_o
);
  localparam logic signed [W-1:0] HI = {{(W-16){Q213_MAX[15]}}, Q213_MAX};
  localparam logic signed [W-1:0] LO = {{(W-16){Q213_MIN[15]}}, Q213_MIN};

  always_comb begin
    sum_o  = acc_i[15:0];
    clip_o = 1'b0;
    if (acc_i > HI) begin
      sum_o  = Q213_MAX;
      clip_o = 1'b1;
    end else if (acc_i < LO) begin
      sum_o  = Q213_MIN;
      clip_o = 1'b1;
    end
  end
endmodule

// File: rtl/dot_product_16.sv
// Q2.13 dot product over up to MAX_LEN elements using an external 16-bit multiplier.
// One element at a time (6 cycles with the standard multiplier); result held until I_RDY.
module dot_product_16 #(
  parameter int MAX_LEN = mha_pkg::MAX_LEN,
  parameter int ACC_W   = mha_pkg::ACC_W
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_VLD,
  output logic        O_RDY,
  input  logic [15:0] I_A,
  input  logic [15:0] I_B,
  input  logic        I_LAST,
  output logic        O_MUL_VLD,
  output logic [15:0] O_MUL_M1,
  output logic [15:0] O_MUL_M2,
  input  logic        I_MUL_BUSY,
  input  logic        I_MUL_VLD,
  input  logic [15:0] I_MUL_PRODUCT,
  output logic        O_VLD,
  input  logic        I_RDY,
  output logic [15:0] O_SUM,
  output logic        O_SAT,
  output logic        O_ERR
);
  import mha_pkg::*;

  localparam int CW = $clog2(MAX_LEN + 1);

  state_e                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic        [CW-1:0]      cnt_q;
  logic        [15:0]        a_q, b_q;
  logic                      last_q;
  logic                      mul_vld_q;
  logic                      vld_q, sat_q, err_q;
  logic        [15:0]        sum_q;
  logic        [15:0]        sat_sum;
  logic                      sat_clip;
  logic                      end_of_vec;

  assign acc_d      = acc_q + {{(ACC_W-16){I_MUL_PRODUCT[15]}}, I_MUL_PRODUCT};
  assign end_of_vec = last_q || (cnt_q == CW'(MAX_LEN));

  sat_q213 #(.W(ACC_W)) u_sat (
    .acc_i  (acc_d),
    .sum_o  (sat_sum),
    .clip_o (sat_clip)
  );

  // Never accept while the shared multiplier is still finishing someone's product.
  assign O_RDY     = (state_q == ST_IDLE) && !I_MUL_BUSY;
  assign O_MUL_VLD = mul_vld_q;
  assign O_MUL_M1  = a_q;
  assign O_MUL_M2  = b_q;
  assign O_VLD     = vld_q;
  assign O_SUM     = sum_q;
  assign O_SAT     = sat_q;
  assign O_ERR     = err_q;

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      last_q    <= 1'b0;
      mul_vld_q <= 1'b0;
      vld_q     <= 1'b0;
      sum_q     <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mul_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (I_VLD && O_RDY) begin
            a_q       <= I_A;
            b_q       <= I_B;
            last_q    <= I_LAST;
            cnt_q     <= cnt_q + CW'(1);
            mul_vld_q <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (I_MUL_VLD) begin
            acc_q <= acc_d;
            if (end_of_vec) begin
              vld_q   <= 1'b1;
              sum_q   <= sat_sum;
              sat_q   <= sat_clip;
              // Only a length overrun can end a vector without I_LAST.
              err_q   <= !last_q;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          if (I_RDY) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/dot_product_16.md
DOT_PRODUCT_16 -- requirements
Module: dot_product_16

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- MAX_LEN  16  max elements per vector
- ACC_W  20  signed accumulator width
REQ-002 SHALL provide these ports, one per line: name  direction  width  meaning.
- I_CLK  in  1  single clock, rising edge.
- I_RST_N  in  1  synchronous, active-low reset.
- I_VLD  in  1  element valid
- O_RDY  out  1  element ready
- I_A  in  16  Q2.13 element a
- I_B  in  16  Q2.13 element b
- I_LAST  in  1  final element of vector
- O_MUL_VLD  out  1  start pulse to the 16-bit multiplier
- O_MUL_M1  out  16  multiplicand
- O_MUL_M2  out  16  multiplier operand
- I_MUL_BUSY  in  1  multiplier busy
- I_MUL_VLD  in  1  product valid, one cycle
- I_MUL_PRODUCT  in  16  Q2.13 product
- O_VLD  out  1  result valid
- I_RDY  in  1  result accepted
- O_SUM  out  16  saturated Q2.13 dot product
- O_SAT  out  1  O_SUM was clipped
- O_ERR  out  1  vector truncated at MAX_LEN

Function
REQ-003 SHALL implement FSM IDLE, ISSUE, WAIT, DONE.
REQ-004 IDLE: O_RDY = 1 only when I_MUL_BUSY = 0; on I_VLD & O_RDY, SHALL capture I_A, I_B and I_LAST, increment the element count, and go to ISSUE.
REQ-005 ISSUE: SHALL drive O_MUL_VLD = 1 for exactly one cycle with O_MUL_M1 = captured a and O_MUL_M2 = captured b, then go to WAIT.
REQ-006 O_MUL_M1 and O_MUL_M2 SHALL hold their values from ISSUE until I_MUL_VLD.
REQ-007 WAIT: on I_MUL_VLD, SHALL add the sign-extended I_MUL_PRODUCT to the ACC_W accumulator.
- If the element was last, or the count reached MAX_LEN, SHALL go to DONE.
- Otherwise SHALL return to IDLE.
REQ-008 With the standard multiplier, I_MUL_VLD arrives 4 cycles after the O_MUL_VLD cycle, giving 6 cycles per element; correctness SHALL NOT depend on this count.
REQ-009 I_MUL_VLD outside WAIT SHALL be ignored.
REQ-010 DONE: O_VLD = 1.
- O_SUM = accumulator clipped to [0x8000, 0x7FFF]; O_SAT = 1 if clipped.
- O_ERR = 1 if MAX_LEN was reached without I_LAST.
- O_VLD, O_SUM, O_SAT and O_ERR SHALL be registered and held stable until I_RDY.
REQ-011 On the cycle I_RDY is seen in DONE, SHALL clear the accumulator and the count and go to IDLE; O_VLD drops the next cycle.
REQ-012 O_RDY SHALL be 0 in ISSUE, WAIT and DONE; a single vector is in flight at a time.
REQ-013 I_LAST on the first element SHALL give a 1-element result.
REQ-014 The accumulator SHALL NOT wrap: MAX_LEN × 16-bit values fit in ACC_W = 20.

Reset
REQ-015 When I_RST_N = 0 at a rising edge, SHALL clear to zero: state (IDLE), accumulator, count, captured operands and all outputs.
- O_RDY follows the IDLE rule after reset.
REQ-016 Reset mid-operation SHALL abandon the vector with no output.
- A later stale I_MUL_VLD SHALL be ignored (REQ-009).

Structure
REQ-017 Shared package mha_pkg SHALL hold: Q2.13 constants (ONE = 0x2000, MAX = 0x7FFF, MIN = 0x8000), MAX_LEN, ACC_W and the FSM state enum.
REQ-018 Clipping SHALL be a sub-module sat_q213 (ACC_W in, 16 bits plus clip flag out); the multiplier SHALL remain external.
REQ-019 Target size is 120-400 lines of RTL.

Verification (bench connects the real multiplier)
REQ-020 Single element, a = 0x2000, b = 0x2000, I_LAST -> O_SUM = 0x2000, O_SAT = 0, O_ERR = 0.
REQ-021 Four elements of 0x2000 × 0x1000, last on the 4th -> O_SUM = 0x4000.
- O_MUL_VLD pulses exactly 4 times.
- O_RDY never high while I_MUL_BUSY = 1.
REQ-022 Eight elements of 0x2000 × 0x3000 -> O_SUM = 0x7FFF, O_SAT = 1; with a = 0xE000 -> O_SUM = 0x8000, O_SAT = 1.
REQ-023 I_RDY held low 5 cycles in DONE -> O_VLD, O_SUM, O_SAT and O_ERR stable, O_RDY = 0; the next vector starts from a zero accumulator.
REQ-024 17 elements of 0x2000 × 0x0100 with no I_LAST -> result after the 16th element: O_SUM = 0x1000, O_ERR = 1; the 17th element is accepted as a new vector.
REQ-025 I_RST_N low for 1 cycle during WAIT -> all outputs 0 the next cycle; the stale I_MUL_VLD is ignored; the next 1-element vector gives the correct O_SUM.
